// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode constants, ALU operation encoding and the decoded-field bundle
// that the decoder hands to the decode/issue pipeline slot.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_EQ,
    ALU_NE,
    ALU_PASS
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [31:0] oper1;
    logic [31:0] oper2;
    alu_op_e     sel_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        branch;
    logic        br_invert;
    logic        illegal;
  } dec_fields_t;

  // alt selects SUB/SRA for the funct3 codes that have an alternate form.
  function automatic alu_op_e f3_to_op(logic [2:0] f3, logic alt);
    alu_op_e op;
    unique case (f3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_stage_decoder.sv
// Combinational RV32I decoder: selects ALU operands and operation for one instruction.
module instr_decoder
  import decode_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  output dec_fields_t dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic        is_shift;
  logic        legal;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7   = instr_i[31:25];
  assign imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u    = {instr_i[31:12], 12'b0};
  assign is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);

  always_comb begin
    dec_o        = '0;
    dec_o.oper1  = rs1_data_i;
    dec_o.oper2  = rs2_data_i;
    dec_o.sel_op = ALU_PASS;
    dec_o.rd     = instr_i[11:7];
    legal        = 1'b1;

    unique case (opcode)
      OPC_OP: begin
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
        dec_o.sel_op = f3_to_op(funct3, funct7 == F7_ALT);
      end
      OPC_OP_IMM: begin
        dec_o.oper2  = imm_i;
        dec_o.sel_op = f3_to_op(funct3, 1'b0);
        if (is_shift) begin
          // shamt only; upper immediate bits act as funct7
          dec_o.oper2  = {27'b0, instr_i[24:20]};
          legal        = (funct7 == F7_BASE) || ((funct3 == F3_SR) && (funct7 == F7_ALT));
          dec_o.sel_op = f3_to_op(funct3, funct7 == F7_ALT);
        end
      end
      OPC_LUI: begin
        dec_o.oper1 = imm_u;
        dec_o.oper2 = '0;
      end
      OPC_AUIPC: begin
        dec_o.oper1  = pc_i;
        dec_o.oper2  = imm_u;
        dec_o.sel_op = ALU_ADD;
      end
      OPC_BRANCH: begin
        dec_o.branch = 1'b1;
        unique case (funct3)
          F3_BEQ:  dec_o.sel_op = ALU_EQ;
          F3_BNE:  dec_o.sel_op = ALU_NE;
          F3_BLT:  dec_o.sel_op = ALU_SLT;
          F3_BGE:  dec_o.sel_op = ALU_SLT;
          F3_BLTU: dec_o.sel_op = ALU_SLTU;
          F3_BGEU: dec_o.sel_op = ALU_SLTU;
          default: legal = 1'b0;
        endcase
        dec_o.br_invert = (funct3 == F3_BGE) || (funct3 == F3_BGEU);
      end
      default: legal = 1'b0;
    endcase

    dec_o.rd_we = legal && !dec_o.branch && (dec_o.rd != 5'd0);
    if (!legal) begin
      dec_o.illegal   = 1'b1;
      dec_o.sel_op    = ALU_PASS;
      dec_o.rd_we     = 1'b0;
      dec_o.branch    = 1'b0;
      dec_o.br_invert = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode/issue stage: valid/ready handshake with fetch and a single registered slot
// feeding execute, with backpressure and flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter alu_op_e RESET_PC_OP = ALU_PASS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  output logic        instr_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic [4:0]  rs1_addr_o,
  output logic [4:0]  rs2_addr_o,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        ex_valid_o,
  input  logic        ex_ready_i,
  output logic [31:0] oper1_o,
  output logic [31:0] oper2_o,
  output alu_op_e     sel_op_o,
  output logic [4:0]  rd_o,
  output logic        rd_we_o,
  output logic        branch_o,
  output logic        br_invert_o,
  output logic        illegal_o
);

  localparam dec_fields_t SlotRst = '{
    oper1: 32'd0, oper2: 32'd0, sel_op: RESET_PC_OP, rd: 5'd0,
    rd_we: 1'b0, branch: 1'b0, br_invert: 1'b0, illegal: 1'b0
  };

  dec_fields_t dec;
  dec_fields_t slot_d, slot_q;
  logic        valid_d, valid_q;
  logic        accept;

  instr_decoder u_decoder (
    .instr_i    (instr_i),
    .pc_i       (pc_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .dec_o      (dec)
  );

  assign rs1_addr_o    = instr_i[19:15];
  assign rs2_addr_o    = instr_i[24:20];
  assign instr_ready_o = !valid_q || ex_ready_i;
  assign accept        = instr_valid_i && instr_ready_o && !flush_i;

  always_comb begin
    slot_d  = slot_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      slot_d  = dec;
    end else if (ex_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      slot_q  <= SlotRst;
    end else begin
      valid_q <= valid_d;
      slot_q  <= slot_d;
    end
  end

  assign ex_valid_o  = valid_q;
  assign oper1_o     = slot_q.oper1;
  assign oper2_o     = slot_q.oper2;
  assign sel_op_o    = slot_q.sel_op;
  assign rd_o        = slot_q.rd;
  assign rd_we_o     = slot_q.rd_we;
  assign branch_o    = slot_q.branch;
  assign br_invert_o = slot_q.br_invert;
  assign illegal_o   = slot_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// checked against a behavioural slot/decode model.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        flush = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [31:0] oper1, oper2;
  alu_op_e     sel_op;
  logic [4:0]  rd;
  logic        rd_we, branch, br_invert, illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_valid_i (instr_valid),
    .instr_ready_o (instr_ready),
    .instr_i       (instr),
    .pc_i          (pc),
    .rs1_addr_o    (rs1_addr),
    .rs2_addr_o    (rs2_addr),
    .rs1_data_i    (rs1_data),
    .rs2_data_i    (rs2_data),
    .flush_i       (flush),
    .ex_valid_o    (ex_valid),
    .ex_ready_i    (ex_ready),
    .oper1_o       (oper1),
    .oper2_o       (oper2),
    .sel_op_o      (sel_op),
    .rd_o          (rd),
    .rd_we_o       (rd_we),
    .branch_o      (branch),
    .br_invert_o   (br_invert),
    .illegal_o     (illegal)
  );

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    alu_op_e     op;
    logic [4:0]  rd;
    bit          we;
    bit          br;
    bit          inv;
    bit          ill;
    bit          chk_ops;
    bit          chk_op2;
    bit          chk_rd;
  } exp_t;

  // Reference model written from the ISA rules as plain integer arithmetic.
  function automatic exp_t model(logic [31:0] w, logic [31:0] p, logic [31:0] a,
                                 logic [31:0] b);
    exp_t e;
    int opc = int'(w & 32'h7F);
    int f3  = int'((w >> 12) & 32'h7);
    int f7  = int'(w >> 25);
    int imm = int'($signed(w)) >>> 20;
    bit ok  = 1;
    e.rd  = w[11:7];
    e.op1 = a; e.op2 = b; e.op = ALU_PASS;
    e.br = 0; e.inv = 0; e.chk_ops = 1; e.chk_op2 = 1; e.chk_rd = 1;
    if (opc == 'h33 || opc == 'h13) begin
      bit sub = (f7 == 32);
      bit shift = (f3 == 1 || f3 == 5);
      if (opc == 'h33) ok = (f7 == 0) || (sub && (f3 == 0 || f3 == 5));
      else if (shift) ok = (f7 == 0) || (sub && f3 == 5);
      if (opc == 'h13) begin
        e.op2 = shift ? ((w >> 20) & 32'h1F) : imm;
        if (!shift) sub = 0;
      end
      case (f3)
        0: e.op = sub ? ALU_SUB : ALU_ADD;
        1: e.op = ALU_SLL;
        2: e.op = ALU_SLT;
        3: e.op = ALU_SLTU;
        4: e.op = ALU_XOR;
        5: e.op = sub ? ALU_SRA : ALU_SRL;
        6: e.op = ALU_OR;
        default: e.op = ALU_AND;
      endcase
    end else if (opc == 'h37) begin
      e.op1 = (w >> 12) << 12; e.chk_op2 = 0;
    end else if (opc == 'h17) begin
      e.op1 = p; e.op2 = (w >> 12) * 4096; e.op = ALU_ADD;
    end else if (opc == 'h63) begin
      e.br = 1; e.chk_rd = 0;
      e.inv = (f3 == 5 || f3 == 7);
      if (f3 == 0) e.op = ALU_EQ;
      else if (f3 == 1) e.op = ALU_NE;
      else if (f3 == 4 || f3 == 5) e.op = ALU_SLT;
      else if (f3 == 6 || f3 == 7) e.op = ALU_SLTU;
      else ok = 0;
    end else begin
      ok = 0;
    end
    e.ill = !ok;
    e.we = ok && !e.br && (e.rd != 0);
    if (!ok) begin
      e.op = ALU_PASS; e.br = 0; e.inv = 0; e.chk_ops = 0; e.chk_rd = 0;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    int kind = $urandom_range(0, 6);
    logic [6:0] f7s [3] = '{7'h00, 7'h20, 7'h00};
    f7s[2] = 7'($urandom);
    case (kind)
      0: w = {f7s[$urandom_range(0, 2)], w[24:7], OPC_OP};
      1: w = {f7s[$urandom_range(0, 2)], w[24:7], OPC_OP_IMM};
      2: w = {w[31:7], OPC_OP_IMM};
      3: w = {w[31:7], OPC_LUI};
      4: w = {w[31:7], OPC_AUIPC};
      5: w = {w[31:7], OPC_BRANCH};
      default: ;
    endcase
    return w;
  endfunction

  // Offer one instruction with execute ready, leave it in the slot afterwards.
  task automatic issue(input logic [31:0] w, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic rdy_after);
    @(negedge clk);
    instr_valid = 1'b1; instr = w; pc = p; rs1_data = a; rs2_data = b;
    ex_ready = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;
    instr_valid = 1'b0; ex_ready = rdy_after;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (ex_valid !== 1'b0 || oper1 !== 32'd0 || oper2 !== 32'd0 || rd !== 5'd0) begin
      fails++;
      $display("FAIL reset_slot: valid=%b op1=%h op2=%h rd=%0d, required 0/0/0/0",
               ex_valid, oper1, oper2, rd);
    end
    tests++;
    if (sel_op !== ALU_PASS || {rd_we, branch, br_invert, illegal} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: sel_op=%0d flags=%b, required %0d/0000", sel_op,
               {rd_we, branch, br_invert, illegal}, ALU_PASS);
    end
    tests++;
    if (instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 1", instr_ready);
    end
  endtask

  task automatic test_alu_ops();
    issue(32'hFFD08293, 32'h100, 32'd10, 32'd0, 1'b0);
    tests++;
    if (ex_valid !== 1'b1 || oper1 !== 32'h0000000A || oper2 !== 32'hFFFFFFFD ||
        sel_op !== ALU_ADD || rd !== 5'd5 || rd_we !== 1'b1) begin
      fails++;
      $display("FAIL addi: v=%b op1=%h op2=%h op=%0d rd=%0d we=%b, required 1/a/fffffffd/%0d/5/1",
               ex_valid, oper1, oper2, sel_op, rd, rd_we, ALU_ADD);
    end
    issue(32'h402081B3, 32'h104, 32'd7, 32'd9, 1'b0);
    tests++;
    if (oper1 !== 32'd7 || oper2 !== 32'd9 || sel_op !== ALU_SUB || rd !== 5'd3) begin
      fails++;
      $display("FAIL sub: op1=%h op2=%h op=%0d rd=%0d, required 7/9/%0d/3",
               oper1, oper2, sel_op, rd, ALU_SUB);
    end
    issue(32'h123453B7, 32'h108, 32'd1, 32'd2, 1'b1);
    tests++;
    if (oper1 !== 32'h12345000 || sel_op !== ALU_PASS || rd !== 5'd7 || rd_we !== 1'b1) begin
      fails++;
      $display("FAIL lui: op1=%h op=%0d rd=%0d we=%b, required 12345000/%0d/7/1",
               oper1, sel_op, rd, rd_we, ALU_PASS);
    end
  endtask

  task automatic test_backpressure();
    issue(32'hFFD08293, 32'h200, 32'd10, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      instr_valid = 1'b1; instr = 32'h123453B7; rs1_data = 32'h55;
      #1;
      tests++;
      if (instr_ready !== 1'b0 || ex_valid !== 1'b1 || oper1 !== 32'h0000000A ||
          oper2 !== 32'hFFFFFFFD || sel_op !== ALU_ADD) begin
        fails++;
        $display("FAIL stall_hold[%0d]: rdy=%b v=%b op1=%h op2=%h op=%0d", i,
                 instr_ready, ex_valid, oper1, oper2, sel_op);
      end
    end
    @(negedge clk);
    ex_ready = 1'b1;
    #1;
    tests++;
    if (instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL stall_release_ready: got %b, required 1", instr_ready);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    tests++;
    if (ex_valid !== 1'b1 || oper1 !== 32'h12345000 || sel_op !== ALU_PASS) begin
      fails++;
      $display("FAIL stall_next: v=%b op1=%h op=%0d, required 1/12345000/%0d",
               ex_valid, oper1, sel_op, ALU_PASS);
    end
    @(posedge clk);
    #1;
    tests++;
    if (ex_valid !== 1'b0) begin
      fails++;
      $display("FAIL no_duplicate: ex_valid=%b, required 0", ex_valid);
    end
  endtask

  task automatic test_flush();
    issue(32'hFFD08293, 32'h300, 32'd10, 32'd0, 1'b0);
    @(negedge clk);
    instr_valid = 1'b1; instr = 32'h123453B7; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; instr_valid = 1'b0; ex_ready = 1'b1;
    tests++;
    if (ex_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_kill: ex_valid=%b, required 0", ex_valid);
    end
    @(posedge clk);
    #1;
    tests++;
    if (ex_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_drop: ex_valid=%b, required 0", ex_valid);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words [2] = '{32'hFFFFFFFF, 32'h00002063};
    for (int i = 0; i < 2; i++) begin
      issue(words[i], 32'h400, 32'd1, 32'd2, 1'b1);
      tests++;
      if (ex_valid !== 1'b1 || illegal !== 1'b1 || rd_we !== 1'b0 || branch !== 1'b0 ||
          sel_op !== ALU_PASS) begin
        fails++;
        $display("FAIL illegal[%0d]: v=%b ill=%b we=%b br=%b op=%0d, required 1/1/0/0/%0d",
                 i, ex_valid, illegal, rd_we, branch, sel_op, ALU_PASS);
      end
    end
    issue(32'h0020D063, 32'h404, 32'd3, 32'd4, 1'b1);
    tests++;
    if (sel_op !== ALU_SLT || branch !== 1'b1 || br_invert !== 1'b1 || rd_we !== 1'b0 ||
        illegal !== 1'b0 || oper1 !== 32'd3 || oper2 !== 32'd4) begin
      fails++;
      $display("FAIL bge: op=%0d br=%b inv=%b we=%b ill=%b op1=%h op2=%h, required %0d/1/1/0/0/3/4",
               sel_op, branch, br_invert, rd_we, illegal, oper1, oper2, ALU_SLT);
    end
  endtask

  task automatic test_async_reset();
    issue(32'hFFD08293, 32'h500, 32'd10, 32'd0, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (ex_valid !== 1'b0 || sel_op !== ALU_PASS || oper1 !== 32'd0) begin
      fails++;
      $display("FAIL async_reset: v=%b op=%0d op1=%h, required 0/%0d/0",
               ex_valid, sel_op, oper1, ALU_PASS);
    end
    @(negedge clk);
    rst = 1'b0; ex_ready = 1'b1;
  endtask

  task automatic test_random();
    bit   mv = 0;
    exp_t me;
    bit   v, exr, fl, acc;
    @(negedge clk);
    instr_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    @(posedge clk);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      tests++;
      if (ex_valid !== mv) begin
        fails++;
        $display("FAIL rnd_valid[%0d]: got %b, required %b", n, ex_valid, mv);
      end
      if (mv) begin
        tests++;
        if (sel_op !== me.op || rd_we !== me.we || branch !== me.br ||
            br_invert !== me.inv || illegal !== me.ill) begin
          fails++;
          $display("FAIL rnd_ctrl[%0d]: op=%0d we=%b br=%b inv=%b ill=%b, required %0d/%b/%b/%b/%b",
                   n, sel_op, rd_we, branch, br_invert, illegal, me.op, me.we, me.br,
                   me.inv, me.ill);
        end
        if (me.chk_ops) begin
          tests++;
          if (oper1 !== me.op1 || (me.chk_op2 && oper2 !== me.op2)) begin
            fails++;
            $display("FAIL rnd_ops[%0d]: op1=%h op2=%h, required %h/%h", n, oper1, oper2,
                     me.op1, me.op2);
          end
        end
        if (me.chk_rd) begin
          tests++;
          if (rd !== me.rd) begin
            fails++;
            $display("FAIL rnd_rd[%0d]: got %0d, required %0d", n, rd, me.rd);
          end
        end
      end
      v   = ($urandom_range(0, 3) != 0);
      exr = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      instr_valid = v; instr = gen_instr(); pc = $urandom;
      rs1_data = $urandom; rs2_data = $urandom; ex_ready = exr; flush = fl;
      #1;
      tests++;
      if (instr_ready !== (!mv || exr) || rs1_addr !== instr[19:15] ||
          rs2_addr !== instr[24:20]) begin
        fails++;
        $display("FAIL rnd_comb[%0d]: rdy=%b a1=%0d a2=%0d, required %b/%0d/%0d", n,
                 instr_ready, rs1_addr, rs2_addr, !mv || exr, instr[19:15], instr[24:20]);
      end
      acc = v && (!mv || exr) && !fl;
      if (fl) mv = 0;
      else if (acc) begin
        mv = 1;
        me = model(instr, pc, rs1_data, rs2_data);
      end else if (exr) mv = 0;
    end
    @(negedge clk);
    instr_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_reset();
    test_alu_ops();
    test_backpressure();
    test_flush();
    test_illegal();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I decode/issue pipeline stage that produces the ALU's operand and operation inputs (oper1, oper2, alu_op_e) from a fetched instruction.
- Sits between fetch and execute.
- Accepts one instruction per handshake, decodes and selects operands, and registers the result into a valid/ready pipeline slot consumed by execute.
- Supports stall (backpressure) and flush.

Parameters:
- RESET_PC_OP, ALU_PASS, operation driven on sel_op_o while idle/reset (type alu_op_e).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- instr_valid_i  input  1  fetch presents instr_i/pc_i.
- instr_ready_o  output  1  stage can accept this cycle.
- instr_i  input  32  instruction word.
- pc_i  input  32  PC of instr_i.
- rs1_addr_o  output  5  combinational instr_i[19:15] to register file.
- rs2_addr_o  output  5  combinational instr_i[24:20] to register file.
- rs1_data_i  input  32  register file read data (same cycle).
- rs2_data_i  input  32  register file read data (same cycle).
- flush_i  input  1  kill slot contents and any instruction offered this cycle.
- ex_valid_o  output  1  slot holds a decoded instruction.
- ex_ready_i  input  1  execute consumes slot this cycle.
- oper1_o  output  32  ALU operand 1.
- oper2_o  output  32  ALU operand 2.
- sel_op_o  output  alu_op_e  ALU operation.
- rd_o  output  5  destination register.
- rd_we_o  output  1  writeback enable; forced 0 when rd=0.
- branch_o  output  1  conditional branch; ALU result is the compare.
- br_invert_o  output  1  take branch when ALU result is 0 (BGE/BGEU).
- illegal_o  output  1  unsupported encoding.

Behaviour:
- Reset: ex_valid_o=0, oper1_o=oper2_o=0, sel_op_o=RESET_PC_OP, rd_o=0, rd_we_o=branch_o=br_invert_o=illegal_o=0.
- instr_ready_o = !ex_valid_o || ex_ready_i. Combinational; no dependency on instr_valid_i.
- Accept = instr_valid_i && instr_ready_o && !flush_i. On accept, decoded fields load into the slot. Latency 1 cycle: outputs are valid the cycle after accept.
- Consume without accept: ex_valid_o && ex_ready_i && !accept sets ex_valid_o=0 next cycle; payload is held (don't-care).
- While ex_valid_o && !ex_ready_i, all slot outputs hold bit-stable.
- flush_i has priority over accept and stall: ex_valid_o=0 next cycle; the offered instruction is dropped.
- Asynchronous reset mid-stall clears the slot immediately.
- Decode (I-type immediates sign-extended from bit 31):
  - OP (0110011): oper1=rs1, oper2=rs2. funct3 mapping: 000 ADD, or SUB when funct7=0100000; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA when funct7=0100000; 110 OR; 111 AND. Any other funct7 is illegal.
  - OP-IMM (0010011): oper1=rs1, oper2=imm_i, same funct3 map without SUB. Shifts: oper2={27'b0, shamt}. funct7 must be 0000000, or 0100000 for SRAI only; otherwise illegal.
  - LUI (0110111): oper1={imm[31:12],12'b0}, ALU_PASS.
  - AUIPC (0010111): oper1=pc_i, oper2={imm[31:12],12'b0}, ALU_ADD.
  - BRANCH (1100011): oper1=rs1, oper2=rs2, branch_o=1, rd_we_o=0. funct3 mapping: 000 EQ; 001 NE; 100 SLT; 101 SLT with invert; 110 SLTU; 111 SLTU with invert. 010/011 are illegal.
  - Any other opcode: illegal.
- Illegal: illegal_o=1, sel_op=ALU_PASS, rd_we_o=0, branch_o=0. The slot is still valid so execute can trap.
- rd_we_o=1 only for legal OP/OP-IMM/LUI/AUIPC with rd≠0.

Decomposition:
- Opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_BRANCH), funct3/funct7 constants and a decoded-fields struct (dec_fields_t) go in the shared constants package alongside alu_op_e.
- One combinational sub-module, instr_decoder: instr_i, pc_i, rs data in; dec_fields_t out.
- decode_stage holds only the handshake and pipeline register.

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293), rs1_data=10, ex_ready=1 → next cycle ex_valid=1, oper1=0x0000000A, oper2=0xFFFFFFFD, sel_op=ALU_ADD, rd=5, rd_we=1.
- SUB x3,x1,x2 (0x402081B3), rs1=7, rs2=9 → sel_op=ALU_SUB, oper1=7, oper2=9, rd=3. LUI x7,0x12345 (0x123453B7) → oper1=0x12345000, ALU_PASS.
- Backpressure: load ADDI, hold ex_ready=0 for 3 cycles while offering LUI → instr_ready=0, outputs unchanged. Raise ex_ready → LUI accepted that cycle and visible next cycle, with no bubble and no duplicate.
- Flush: slot valid and stalled, assert flush_i with instr_valid=1 → next cycle ex_valid=0; the offered instruction never appears.
- Illegal: 0xFFFFFFFF and BRANCH funct3=010 → illegal_o=1, rd_we=0, branch_o=0. BGE (funct3 101) → ALU_SLT, branch_o=1, br_invert_o=1.
- Async reset asserted mid-cycle with slot valid → ex_valid_o=0 and sel_op=ALU_PASS before the next clock edge.
